// File: rtl/bit_population_pkg.sv
// rtl/bit_population_pkg.sv - shared types and LFSR step for the bit population generator
package bit_population_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} bpg_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Galois step, right shift, taps x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/bit_population_generator_lfsr16.sv
// rtl/bit_population_generator_lfsr16.sv - 16-bit Galois LFSR with seed load on reset
module lfsr16
  import bit_population_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        en,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/bit_population_generator.sv
// rtl/bit_population_generator.sv - emits a WIDTH-bit word with exactly min(n, WIDTH) bits set
module bit_population_generator
  import bit_population_pkg::*;
#(
  parameter int          WIDTH = 5,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int         CW    = $clog2(WIDTH) + 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [CW-1:0]    data_i,
  input  logic             data_val_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             data_val_o,
  output logic             data_sat_o
);

  localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);

  bpg_state_t       state;
  logic [CW-1:0]    rem;
  logic             sat;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] pick;
  logic [15:0]      lfsr;
  logic             lfsr_en;
  logic [31:0]      p;
  logic [31:0]      s;
  logic             found;

  assign lfsr_en = (state == FILL);

  lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .en     (lfsr_en),
    .lfsr   (lfsr)
  );

  // Walk positions p, p+1, ... wrapping, and take the first free one
  always_comb begin
    p     = 32'(lfsr) % 32'(WIDTH);
    s     = '0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = p + 32'(i);
      if (s >= 32'(WIDTH)) s = s - 32'(WIDTH);
      if (!found && !work[IW'(s)]) begin
        found          = 1'b1;
        pick[IW'(s)]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state      <= IDLE;
      rem        <= '0;
      sat        <= 1'b0;
      work       <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
      data_sat_o <= 1'b0;
      ready_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_val_o <= 1'b0;
          data_sat_o <= 1'b0;
          ready_o    <= 1'b1;
          if (data_val_i && ready_o) begin
            ready_o <= 1'b0;
            work    <= '0;
            sat     <= (data_i > WIDTH_C);
            rem     <= (data_i > WIDTH_C) ? WIDTH_C : data_i;
            if (data_i == '0) begin
              state      <= DONE;
              data_o     <= '0;
              data_val_o <= 1'b1;
              data_sat_o <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          work <= work | pick;
          rem  <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state      <= DONE;
            data_o     <= work | pick;
            data_val_o <= 1'b1;
            data_sat_o <= sat;
          end
        end
        DONE: begin
          data_val_o <= 1'b0;
          data_sat_o <= 1'b0;
          ready_o    <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_population_generator.md
# bit_population_generator

- Inverse of the population counter: accepts a requested population `n` and emits a `WIDTH`-bit word containing exactly `min(n, WIDTH)` set bits.
- Bit positions come from a deterministic 16-bit LFSR; one bit is placed per cycle.
- Feeds popcount stimulus and self-checking loops.
- Its input width equals the counter's output width, so the two blocks chain back-to-back.

## Interface
- `WIDTH`, 5, output word width (≥1).
- `SEED`, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- `clk_i`  in  1  single clock, all logic on rising edge.
- `srst_i`  in  1  synchronous reset, active-low (0 = reset).
- `data_i`  in  $clog2(WIDTH)+2  requested population `n`.
- `data_val_i`  in  1  request valid.
- `ready_o`  out  1  block idle, request accepted on `data_val_i & ready_o`.
- `data_o`  out  WIDTH  generated word.
- `data_val_o`  out  1  one-cycle pulse, `data_o` valid.
- `data_sat_o`  out  1  with `data_val_o`: request was clamped (`n > WIDTH`).

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - `ready_o`=1.
  - On accept: latch `rem = min(n, WIDTH)` and `sat = (n > WIDTH)`, clear the work word.
  - Go to FILL if `rem > 0`, else DONE.
- FILL, each cycle:
  - `p = lfsr % WIDTH`.
  - Set the first zero bit of the work word at index ≥ p, wrapping at WIDTH−1 → 0.
  - `rem--`; advance the LFSR.
  - When `rem` reaches 0 after this cycle → DONE.
- DONE:
  - Drive `data_o` = work word, `data_val_o`=1, `data_sat_o`=sat.
  - → IDLE.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, shift right, feedback mask 16'hB400.
  - Advances only in FILL, so output sequences are reproducible from SEED.
- A free position always exists in FILL, because placed bits < `rem0` ≤ WIDTH.
- `data_val_i` is ignored while `ready_o`=0; there is no queueing.
- `data_o` holds its last value until the next DONE; `data_val_o` and `data_sat_o` are 0 outside DONE.

## Timing
- Reset (`srst_i`=0 at an edge):
  - state=IDLE, LFSR=SEED.
  - `data_o`=0, `data_val_o`=0, `data_sat_o`=0.
  - `ready_o`=0 while `srst_i` is low; 1 from the first cycle after release.
- Request accepted at edge t with clamped count k:
  - FILL occupies cycles t+1..t+k.
  - `data_val_o` is high in cycle t+k+1.
  - `ready_o` is high again in cycle t+k+2.
- k=0: `data_val_o` high in cycle t+1 with `data_o`=0.
- Throughput: one request per k+2 cycles.
- Reset mid-FILL or mid-DONE: aborts immediately, no `data_val_o`, LFSR reloads SEED.
- Back-to-back: `data_val_i` held high across DONE is accepted at the first IDLE edge only.

## Structure
- Package `bit_population_pkg` holds:
  - state enum `bpg_state_t` {IDLE, FILL, DONE};
  - `LFSR_MASK` = 16'hB400;
  - function `lfsr_next()`.
- Bench reference model imports the same package.
- Sub-module `lfsr16` (enable, seed load on reset, 16-bit state out).
- Rotate-and-priority free-bit search stays inline as combinational logic.
- Count width `$clog2(WIDTH)+2`, matching the counter output.

## Test plan
- Reset: hold `srst_i`=0 for 3 cycles while `data_val_i`=1 → `ready_o`=0, `data_val_o`=0, `data_o`=0; first accept occurs one cycle after release.
- WIDTH=5, n=3 accepted at t → `data_val_o` pulse exactly at t+4; popcount(`data_o`)=3; `data_sat_o`=0; pattern equals the model from SEED=16'hACE1.
- n=0 → `data_val_o` at t+1, `data_o`=0; n=5 → `data_o`=5'b11111 at t+6.
- n=7 with WIDTH=5 → `data_o`=5'b11111, `data_sat_o`=1, latency 6.
- Loop through `bit_population_counter`: 1000 random n in 0..5, each `data_o` fed back → counter output equals min(n, 5) every time.
- Reset asserted during FILL of n=5 (after 2 placements) → no `data_val_o`, `ready_o` returns; next n=2 reproduces the sequence from a fresh SEED.
